// File: rtl/gray_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full flag, fill level and sticky overflow flag.

module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

module gray_wptr_ctrl #(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    input  logic                  ovf_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   fill,
    output logic                  ovf
);
    localparam int W = ADDR_WIDTH + 1;

    logic [W-1:0] wbin;
    logic [W-1:0] wbin_next;
    logic [W-1:0] wgray_next;
    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] rq_sync;
    logic [W-1:0] rbin_sync;
    logic [W-1:0] full_target;
    logic         acc;

    assign wr_accept = wr_en & ~full;
    assign waddr     = wbin[ADDR_WIDTH-1:0];
    assign wbin_next = wbin + W'(wr_accept);

    bin2gray #(.WIDTH(W)) u_bin2gray (
        .bin  (wbin_next),
        .gray (wgray_next)
    );

    // Plain flop chain: nothing may sit between the synchroniser stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        rbin_sync = '0;
        acc       = 1'b0;
        for (int i = 0; i < W; i++) begin
            acc = 1'b0;
            for (int j = i; j < W; j++) begin
                acc = acc ^ rq_sync[j];
            end
            rbin_sync[i] = acc;
        end
    end

    // Full when the write pointer is one lap ahead of the synchronised read pointer.
    assign full_target = {~rq_sync[W-1:W-2], rq_sync[W-3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            fill      <= '0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            full      <= (wgray_next == full_target);
            fill      <= wbin_next - rbin_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
endmodule

// File: doc/gray_wptr_ctrl.md
Name: gray_wptr_ctrl

Overview:
Write-side pointer controller for a dual-clock FIFO, built around the Bin2Gray converter.
- Keeps the binary write pointer and derives the Gray-coded pointer through a Bin2Gray instance for export across the clock boundary.
- Synchronises the incoming Gray read pointer and generates the full flag, the fill level and a sticky overflow flag.
- Sits in the write clock domain, between the write requester and the FIFO RAM / read-side controller.

Parameters:
ADDR_WIDTH, 3, RAM address width; depth = 2**ADDR_WIDTH; must be >= 2.
SYNC_STAGES, 2, flops in the read-pointer synchroniser; must be >= 2.

Ports:
clk  input  1  write-domain clock, rising edge.
rst  input  1  synchronous reset, active-high.
wr_en  input  1  write request for the current cycle.
rptr_gray_async  input  ADDR_WIDTH+1  Gray read pointer from the read domain, asynchronous.
ovf_clr  input  1  clears the sticky overflow flag.
wr_accept  output  1  combinational; wr_en & ~full; RAM write strobe.
waddr  output  ADDR_WIDTH  RAM write address; low bits of the binary pointer.
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, exported to the read domain.
full  output  1  registered FIFO-full flag.
fill  output  ADDR_WIDTH+1  registered occupancy as seen from the write domain, 0..2**ADDR_WIDTH.
ovf  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset: rst high at a rising edge sets wbin, wptr_gray, all synchroniser flops, full, fill and ovf to 0 at that edge.
  - Reset overrides wr_en and ovf_clr.
  - During reset, wr_accept = wr_en, because full is 0.
  - Reset in the middle of a burst discards the pointer; the first write after reset goes to address 0.
- Internal binary pointer wbin has width ADDR_WIDTH+1; waddr = wbin[ADDR_WIDTH-1:0].
- wbin_next = wbin + wr_accept, modulo 2**(ADDR_WIDTH+1).
  - Wrap from all-ones to 0 is natural; there is no special case.
- wgray_next = Bin2Gray(wbin_next), using a combinational instance with WIDTH = ADDR_WIDTH+1.
  - wbin and wptr_gray both register at every edge.
  - wptr_gray always equals Bin2Gray(wbin) and changes exactly one bit per accepted write.
- Synchroniser: SYNC_STAGES-deep shift register on rptr_gray_async; the output is rq_sync.
  - No logic is allowed between the synchroniser stages.
- rbin_sync = Gray-to-binary conversion of rq_sync, combinational: bit i = XOR of rq_sync[ADDR_WIDTH:i].
- full <= (wgray_next == {~rq_sync[ADDR_WIDTH:ADDR_WIDTH-1], rq_sync[ADDR_WIDTH-2:0]}).
- fill <= wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1); the value is never larger than 2**ADDR_WIDTH.
- Latency:
  - A write accepted in cycle N updates waddr, wptr_gray, full and fill in cycle N+1.
  - A change on rptr_gray_async reaches full/fill after SYNC_STAGES+1 edges.
  - full is pessimistic: it deasserts late, never early.
- Write while full: no pointer change and wr_accept = 0. ovf <= 1 at the same edge.
- ovf: set has priority over clear.
  - If an overflow attempt and ovf_clr occur in the same cycle, ovf = 1.
  - Otherwise ovf_clr drives ovf to 0 at the next edge.
- Simultaneous cases:
  - The write that makes the FIFO full is accepted; full asserts in the next cycle.
  - A read that frees space in the same cycle a write is blocked does not admit that write. The write waits for the synchronised pointer.
- Gray-code legality: any two consecutive values on wptr_gray differ by exactly one bit. This includes the wrap 10..0 -> 00..0.

Test Plan:
- Reset, then idle with rptr_gray_async=0 -> waddr=0, wptr_gray=0000, full=0, fill=0, ovf=0, wr_accept=0.
- 8 consecutive writes, rptr held at 0, ADDR_WIDTH=3:
  - waddr steps 1..7,0 and wptr_gray steps 0001,0011,0010,0110,0111,0101,0100,1100.
  - full=1 and fill=8 in the cycle after the 8th write.
- 9th write while full -> wr_accept=0, pointers unchanged, ovf=1.
  - Later ovf_clr alone -> ovf=0 one cycle later.
  - ovf_clr asserted together with a blocked write -> ovf stays 1.
- With full=1, drive rptr_gray_async=0001 -> full stays 1 for exactly SYNC_STAGES cycles, then full=0 and fill=7 at edge SYNC_STAGES+1.
  - The next write is accepted.
- 20 writes with the reader tracking 2 entries behind:
  - wbin wraps 15->0; wptr_gray passes 1000->0000; full never asserts; fill settles at 2.
  - Every consecutive wptr_gray pair has a Hamming distance of 1.
- Assert rst for one cycle during a burst with wr_en held high -> all outputs 0 after the edge.
  - The next accepted write produces waddr=1 and wptr_gray=0001.
